sidebuf_ctrl: RTL and testbench
===============================

// Module: sidebuf_ctrl
// PURPOSE
// - Side-buffer controller for the MinBD router datapath; sequences the redirect stage.
// - Holds deflected/redirected flits in a small FIFO and offers the head flit for re-injection.
// - Tracks head-of-line starvation and drives starve/full/rand_num into the redirect stage.
// - Accepts the redirected flit back when redirect_gnt fires.
// PARAMETERS
// - DEPTH      4      side-buffer entries; power of 2, >=2
// - STARVE_TH  2      consecutive blocked cycles of a valid head before starve asserts (>=1)
// - LFSR_SEED  8'hA5  LFSR reset value; nonzero
// PORTS
// - clk            in   1          core clock
// - reset          in   1          asynchronous, active-high reset
// - push_req       in   1          buffer-eject stage offers a deflected flit
// - push_flit      in   flit_int_t deflected flit (vld ignored, stored as 1)
// - push_gnt       out  1          deflected flit accepted this cycle
// - redirect_gnt   in   1          redirect stage removed a flit this cycle
// - redirect_flit  in   flit_int_t flit removed by the redirect stage
// - reinject_gnt   in   1          router accepted head_flit into a free slot this cycle
// - head_flit      out  flit_int_t FIFO head; .vld = ~empty, all fields 0 when empty
// - starve         out  1          head blocked >= STARVE_TH cycles (registered)
// - full           out  1          occupancy == DEPTH (registered count)
// - rand_num       out  2          redirect channel select, LFSR[1:0]
// - occupancy      out  $clog2(DEPTH+1)  current entry count
// - redirect_cnt   out  16         redirect statistics (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): rd_ptr, wr_ptr, occupancy, starve counter and starve = 0; full = 0;
//   head_flit = 0; LFSR = LFSR_SEED; rand_num = LFSR_SEED[1:0]; redirect_cnt = 0.
// - Reset mid-operation discards all buffered flits.
// - Pop: pop = reinject_gnt & ~empty; reinject_gnt while empty is ignored.
// - Push sources: redirect_gnt has priority over push_req; at most one push per cycle.
//   - push_gnt = push_req & ~redirect_gnt & (~full | pop), combinational.
//   - Redirect push requires ~full, which the redirect stage already guarantees.
//   - redirect_gnt while full is dropped and does not corrupt state.
// - Latency: a pushed flit is written at clk edge; it appears on head_flit the next cycle
//   if the FIFO was empty. No bypass.
// - Push and pop in the same cycle: occupancy unchanged. A push is legal when full if a pop
//   occurs in the same cycle.
// - Pointers are log2(DEPTH) bits and wrap naturally; occupancy saturates at DEPTH.
// - Starve counter: increments (saturating at STARVE_TH) when head valid & ~reinject_gnt;
//   clears to 0 on pop or when empty.
//   - starve = (counter == STARVE_TH), registered.
//   - starve falls the cycle after the pop.
//   - After a pop, the new head restarts counting from 0.
// - rand_num: 8-bit Fibonacci LFSR, taps 8,6,5,4, shifts every cycle regardless of traffic.
// - full and starve are both registered; they are stable for the whole cycle the redirect
//   stage samples them.
// CONFIGURATION
// - SIDEBUF_STATS_EN defined:
//   - redirect_cnt increments by 1 on each accepted redirect_gnt, saturating at 16'hFFFF.
//   - Cleared by reset.
// - SIDEBUF_STATS_EN undefined:
//   - redirect_cnt is tied to 16'h0 and no counter flops are built.
//   - All other behaviour is identical.
// TESTING
// - Reset with DEPTH=4, no traffic:
//   - head_flit.vld=0, full=0, starve=0, occupancy=0.
//   - rand_num=2'b01 first cycle; LFSR sequence matches the reference model.
// - Four push_req cycles, reinject_gnt=0:
//   - occupancy 1,2,3,4; full=1 after 4th push.
//   - 5th push_req gets push_gnt=0; head_flit is the first pushed flit.
// - Head valid, reinject_gnt=0, STARVE_TH=2:
//   - starve=1 on the 3rd cycle after head valid.
//   - reinject_gnt pulse -> starve=0 next cycle, counter restarts for the next head.
// - Full FIFO, reinject_gnt=1 and push_req=1 same cycle:
//   - push_gnt=1, occupancy stays 4, FIFO order preserved across pointer wrap.
// - redirect_gnt=1 and push_req=1 same cycle:
//   - redirect_flit stored, push_gnt=0.
//   - With SIDEBUF_STATS_EN, redirect_cnt increments 0->1; without it, it stays 0.
// - Assert reset while occupancy=3 and starve=1:
//   - all outputs return to reset values immediately, asynchronously to clk.

Source files
------------

// File: rtl/sidebuf_ctrl.sv
// ---------------------------------------------------------------------------
// sidebuf_pkg / sidebuf_ctrl
//
// Side-buffer controller for the MinBD router redirect stage. Deflected flits
// from the buffer-eject stage and flits pulled out by the redirect stage are
// held in a small FIFO. The head entry is offered for re-injection into a
// free router slot.
//
// The controller also drives three signals into the redirect stage:
//   - starve   : the head flit has been blocked for STARVE_TH cycles
//   - full     : the FIFO holds DEPTH entries
//   - rand_num : channel select taken from a free-running LFSR
//
// Parameters
//   DEPTH      side-buffer entries (power of 2, >= 2)
//   STARVE_TH  blocked cycles of a valid head before starve asserts (>= 1)
//   LFSR_SEED  LFSR reset value (nonzero)
//
// Ports
//   clk            in   core clock
//   reset          in   asynchronous, active-high reset
//   push_req       in   eject stage offers a deflected flit
//   push_flit      in   deflected flit (incoming vld ignored, stored as 1)
//   push_gnt       out  deflected flit accepted this cycle (combinational)
//   redirect_gnt   in   redirect stage removed a flit this cycle
//   redirect_flit  in   flit removed by the redirect stage
//   reinject_gnt   in   router took head_flit into a free slot this cycle
//   head_flit      out  FIFO head; all zero when empty
//   starve         out  head blocked >= STARVE_TH cycles (registered)
//   full           out  occupancy == DEPTH (registered)
//   rand_num       out  redirect channel select, LFSR[1:0]
//   occupancy      out  current entry count
//   redirect_cnt   out  accepted-redirect statistics counter
//
// Optional feature macro: SIDEBUF_STATS_EN
//   When defined, redirect_cnt counts accepted redirects and saturates at
//   16'hFFFF. When undefined, redirect_cnt is tied to zero and no counter
//   flops are built.
// ---------------------------------------------------------------------------

package sidebuf_pkg;

   typedef struct packed {
      logic       vld;
      logic [3:0] dst;
      logic [7:0] payload;
   } flit_int_t;

endpackage

module sidebuf_ctrl
   import sidebuf_pkg::*;
#(
   parameter int         DEPTH     = 4,
   parameter int         STARVE_TH = 2,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_req,
   input  flit_int_t                    push_flit,
   output logic                         push_gnt,
   input  logic                         redirect_gnt,
   input  flit_int_t                    redirect_flit,
   input  logic                         reinject_gnt,
   output flit_int_t                    head_flit,
   output logic                         starve,
   output logic                         full,
   output logic [1:0]                   rand_num,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [15:0]                  redirect_cnt
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2(STARVE_TH + 1);

   localparam logic [OCC_W-1:0] DEPTH_OCC  = OCC_W'(DEPTH);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_TH);

   flit_int_t               mem [DEPTH];
   logic [PTR_W-1:0]        rd_ptr;
   logic [PTR_W-1:0]        wr_ptr;
   logic [OCC_W-1:0]        occ_next;
   logic [CNT_W-1:0]        starve_cnt;
   logic [CNT_W-1:0]        starve_cnt_next;
   logic [7:0]              lfsr;

   logic                    empty;
   logic                    pop;
   logic                    redirect_push;
   logic                    push;
   flit_int_t               write_flit;

   assign empty = (occupancy == '0);

   // Push/pop arbitration. The redirect stage wins over the eject stage and
   // only needs "not full"; the eject stage may also push into a full FIFO
   // when the head leaves in the same cycle. A redirect while full is simply
   // dropped. Stored flits always carry vld = 1 so the head's vld bit comes
   // straight out of the storage array.
   always_comb begin
      pop            = reinject_gnt & ~empty;
      redirect_push  = redirect_gnt & ~full;
      push_gnt       = push_req & ~redirect_gnt & (~full | pop);
      push           = redirect_push | push_gnt;
      write_flit     = redirect_gnt ? redirect_flit : push_flit;
      write_flit.vld = 1'b1;
   end

   // Storage array is not reset; entries are only visible through head_flit
   // while occupancy says they are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= write_flit;
      end
   end

   assign head_flit = empty ? '0 : mem[rd_ptr];

   always_comb begin
      occ_next = occupancy;
      case ({push, pop})
         2'b10:   occ_next = occupancy + 1'b1;
         2'b01:   occ_next = occupancy - 1'b1;
         default: occ_next = occupancy;
      endcase
   end

   // Pointers wrap naturally because DEPTH is a power of two. full is taken
   // from the next count so it is a flop output that stays stable for the
   // whole cycle the redirect stage samples it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         occupancy <= '0;
         full      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         occupancy <= occ_next;
         full      <= (occ_next == DEPTH_OCC);
      end
   end

   // Starvation tracking for the current head. The count restarts whenever
   // the head leaves (so the next head starts from zero) and is held at zero
   // while the FIFO is empty. starve is registered from the next count, so it
   // drops in the cycle right after a pop.
   always_comb begin
      starve_cnt_next = starve_cnt;
      if (empty || pop) begin
         starve_cnt_next = '0;
      end else if (starve_cnt != STARVE_MAX) begin
         starve_cnt_next = starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
         starve     <= 1'b0;
      end else begin
         starve_cnt <= starve_cnt_next;
         starve     <= (starve_cnt_next == STARVE_MAX);
      end
   end

   // 8-bit Fibonacci LFSR, taps 8,6,5,4, free-running regardless of traffic.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   assign rand_num = lfsr[1:0];

`ifdef SIDEBUF_STATS_EN
   logic [15:0] stat_cnt;

   // Counts redirects that were actually stored; dropped ones do not count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_cnt <= 16'h0;
      end else if (redirect_push && (stat_cnt != 16'hFFFF)) begin
         stat_cnt <= stat_cnt + 16'd1;
      end
   end

   assign redirect_cnt = stat_cnt;
`else
   assign redirect_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_sidebuf_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sidebuf_ctrl
//
// Self-checking bench for sidebuf_ctrl (DEPTH=4, STARVE_TH=2, seed 8'hA5).
// A directed vector table walks the fill/full/wrap/starve/redirect corners,
// a hand sequence checks asynchronous reset from a busy state, and a random
// phase compares every output against a queue-based reference model.
// Honours SIDEBUF_STATS_EN the same way the design does.
// ---------------------------------------------------------------------------

module tb_sidebuf_ctrl;
   import sidebuf_pkg::*;

   localparam int         DEPTH     = 4;
   localparam int         STARVE_TH = 2;
   localparam logic [7:0] SEED      = 8'hA5;

   logic        clk;
   logic        reset;
   logic        push_req;
   flit_int_t   push_flit;
   logic        push_gnt;
   logic        redirect_gnt;
   flit_int_t   redirect_flit;
   logic        reinject_gnt;
   flit_int_t   head_flit;
   logic        starve;
   logic        full;
   logic [1:0]  rand_num;
   logic [2:0]  occupancy;
   logic [15:0] redirect_cnt;

   int checks;
   int failures;

   // Reference model state: plain queue of stored flits, a count of cycles
   // the current head has been waiting, the LFSR value, and the statistics.
   flit_int_t  mq[$];
   int         m_blocked;
   logic [7:0] m_lfsr;
   int         m_rcnt;

   typedef struct {
      logic      push_req;
      flit_int_t push_flit;
      logic      redirect_gnt;
      flit_int_t redirect_flit;
      logic      reinject_gnt;
      logic      exp_gnt;
      int        exp_occ;
      flit_int_t exp_head;
      logic      exp_full;
      logic      exp_starve;
      int        exp_rcnt;
   } vec_t;

   vec_t vecs [18];

   sidebuf_ctrl #(
      .DEPTH     (DEPTH),
      .STARVE_TH (STARVE_TH),
      .LFSR_SEED (SEED)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .push_req      (push_req),
      .push_flit     (push_flit),
      .push_gnt      (push_gnt),
      .redirect_gnt  (redirect_gnt),
      .redirect_flit (redirect_flit),
      .reinject_gnt  (reinject_gnt),
      .head_flit     (head_flit),
      .starve        (starve),
      .full          (full),
      .rand_num      (rand_num),
      .occupancy     (occupancy),
      .redirect_cnt  (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic flit_int_t fl(input logic [3:0] d, input logic [7:0] p);
      flit_int_t f;
      f.vld     = 1'b0;
      f.dst     = d;
      f.payload = p;
      return f;
   endfunction

   function automatic flit_int_t hv(input flit_int_t f);
      flit_int_t h;
      h     = f;
      h.vld = 1'b1;
      return h;
   endfunction

   // LFSR step written as "parity of the tapped bits" (taps 8,6,5,4).
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      logic fb;
      fb = ($countones(s & 8'hB8) % 2) == 1;
      return {s[6:0], fb};
   endfunction

   function automatic vec_t mkv(input logic pr, input flit_int_t pf,
                                input logic rdg, input flit_int_t rf,
                                input logic rg, input logic eg, input int eo,
                                input flit_int_t eh, input logic ef,
                                input logic es, input int er);
      vec_t v;
      v.push_req      = pr;
      v.push_flit     = pf;
      v.redirect_gnt  = rdg;
      v.redirect_flit = rf;
      v.reinject_gnt  = rg;
      v.exp_gnt       = eg;
      v.exp_occ       = eo;
      v.exp_head      = eh;
      v.exp_full      = ef;
      v.exp_starve    = es;
      v.exp_rcnt      = er;
      return v;
   endfunction

   function automatic int stats_exp(input int with_stats);
`ifdef SIDEBUF_STATS_EN
      return with_stats;
`else
      return 0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic pr, input flit_int_t pf,
                                input logic rdg, input flit_int_t rf,
                                input logic rg);
      push_req      = pr;
      push_flit     = pf;
      redirect_gnt  = rdg;
      redirect_flit = rf;
      reinject_gnt  = rg;
   endtask

   // Called at the negedge: optionally compares every output with the model,
   // always compares rand_num, then advances the model across the next edge.
   task automatic modelAdvance(input bit check_all, input string tag);
      bit        m_empty;
      bit        m_full;
      bit        m_pop;
      bit        e_gnt;
      bit        r_acc;
      flit_int_t e_head;
      flit_int_t nf;
      m_empty = (mq.size() == 0);
      m_full  = (mq.size() == DEPTH);
      m_pop   = reinject_gnt && !m_empty;
      e_gnt   = push_req && !redirect_gnt && (!m_full || m_pop);
      r_acc   = redirect_gnt && !m_full;
      e_head  = m_empty ? flit_int_t'(0) : mq[0];

      checkOutput({tag, "_rand_num"}, 32'(rand_num), 32'(m_lfsr[1:0]));
      if (check_all) begin
         checkOutput({tag, "_push_gnt"}, 32'(push_gnt), 32'(e_gnt));
         checkOutput({tag, "_occupancy"}, 32'(occupancy), 32'(mq.size()));
         checkOutput({tag, "_head"}, 32'(head_flit), 32'(e_head));
         checkOutput({tag, "_full"}, 32'(full), 32'(m_full));
         checkOutput({tag, "_starve"}, 32'(starve), 32'(m_blocked >= STARVE_TH));
         checkOutput({tag, "_redirect_cnt"}, 32'(redirect_cnt), 32'(stats_exp(m_rcnt)));
      end

      if (m_empty || m_pop) m_blocked = 0;
      else                  m_blocked++;
      if (m_pop) void'(mq.pop_front());
      if (r_acc) begin
         nf = hv(redirect_flit);
         mq.push_back(nf);
         if (m_rcnt < 65535) m_rcnt++;
      end else if (e_gnt) begin
         nf = hv(push_flit);
         mq.push_back(nf);
      end
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   // Asserts reset, releases it at a negedge, checks the reset values during
   // the first cycle out of reset and steps to just after the next posedge.
   task automatic doReset();
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      mq.delete();
      m_blocked = 0;
      m_lfsr    = SEED;
      m_rcnt    = 0;
      #1;
      checkOutput("rst_head", 32'(head_flit), 32'h0);
      checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
      checkOutput("rst_full", 32'(full), 32'h0);
      checkOutput("rst_starve", 32'(starve), 32'h0);
      checkOutput("rst_rand_num", 32'(rand_num), 32'h1);
      checkOutput("rst_redirect_cnt", 32'(redirect_cnt), 32'h0);
      @(posedge clk);
      m_lfsr = lfsr_next(m_lfsr);
      #1;
   endtask

   initial begin
      flit_int_t z;
      flit_int_t f1, f2, f3, f4, f5, f6, r1, r2;
      flit_int_t rf, pf;
      logic      pr, rg, rdg;

      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);

      z  = '0;
      f1 = fl(4'd1, 8'h11);
      f2 = fl(4'd2, 8'h22);
      f3 = fl(4'd3, 8'h33);
      f4 = fl(4'd4, 8'h44);
      f5 = fl(4'd5, 8'h55);
      f6 = fl(4'd6, 8'h66);
      r1 = fl(4'd9, 8'h91);
      r2 = fl(4'd10, 8'hA2);

      //                 pr  pflit rdg rflit rg | gnt occ head    full stv rcnt
      vecs[0]  = mkv(1'b0, z,  1'b0, z,  1'b0, 1'b0, 0, z,      1'b0, 1'b0, 0);
      vecs[1]  = mkv(1'b1, f1, 1'b0, z,  1'b0, 1'b1, 0, z,      1'b0, 1'b0, 0);
      vecs[2]  = mkv(1'b1, f2, 1'b0, z,  1'b0, 1'b1, 1, hv(f1), 1'b0, 1'b0, 0);
      vecs[3]  = mkv(1'b1, f3, 1'b0, z,  1'b0, 1'b1, 2, hv(f1), 1'b0, 1'b0, 0);
      vecs[4]  = mkv(1'b1, f4, 1'b0, z,  1'b0, 1'b1, 3, hv(f1), 1'b0, 1'b1, 0);
      vecs[5]  = mkv(1'b1, f5, 1'b0, z,  1'b0, 1'b0, 4, hv(f1), 1'b1, 1'b1, 0);
      vecs[6]  = mkv(1'b1, f5, 1'b0, z,  1'b1, 1'b1, 4, hv(f1), 1'b1, 1'b1, 0);
      vecs[7]  = mkv(1'b0, z,  1'b0, z,  1'b0, 1'b0, 4, hv(f2), 1'b1, 1'b0, 0);
      vecs[8]  = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 4, hv(f2), 1'b1, 1'b0, 0);
      vecs[9]  = mkv(1'b1, f6, 1'b1, r1, 1'b0, 1'b0, 3, hv(f3), 1'b0, 1'b0, 0);
      vecs[10] = mkv(1'b0, z,  1'b0, z,  1'b0, 1'b0, 4, hv(f3), 1'b1, 1'b0, 1);
      vecs[11] = mkv(1'b0, z,  1'b1, r2, 1'b0, 1'b0, 4, hv(f3), 1'b1, 1'b1, 1);
      vecs[12] = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 4, hv(f3), 1'b1, 1'b1, 1);
      vecs[13] = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 3, hv(f4), 1'b0, 1'b0, 1);
      vecs[14] = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 2, hv(f5), 1'b0, 1'b0, 1);
      vecs[15] = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 1, hv(r1), 1'b0, 1'b0, 1);
      vecs[16] = mkv(1'b0, z,  1'b0, z,  1'b1, 1'b0, 0, z,      1'b0, 1'b0, 1);
      vecs[17] = mkv(1'b0, z,  1'b0, z,  1'b0, 1'b0, 0, z,      1'b0, 1'b0, 1);

      $display("[TB] directed vector table");
      doReset();
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i].push_req, vecs[i].push_flit, vecs[i].redirect_gnt,
                       vecs[i].redirect_flit, vecs[i].reinject_gnt);
         @(negedge clk);
         checkOutput($sformatf("vec%0d_push_gnt", i), 32'(push_gnt), 32'(vecs[i].exp_gnt));
         checkOutput($sformatf("vec%0d_occupancy", i), 32'(occupancy), 32'(vecs[i].exp_occ));
         checkOutput($sformatf("vec%0d_head", i), 32'(head_flit), 32'(vecs[i].exp_head));
         checkOutput($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
         checkOutput($sformatf("vec%0d_starve", i), 32'(starve), 32'(vecs[i].exp_starve));
         checkOutput($sformatf("vec%0d_redirect_cnt", i), 32'(redirect_cnt),
                     32'(stats_exp(vecs[i].exp_rcnt)));
         modelAdvance(1'b0, $sformatf("vec%0d", i));
         @(posedge clk);
         #1;
      end

      $display("[TB] asynchronous reset from a busy FIFO");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, fl(4'(i), 8'(8'hC0 + i)), 1'b0, '0, 1'b0);
         @(negedge clk);
         modelAdvance(1'b1, $sformatf("fill%0d", i));
         @(posedge clk);
         #1;
      end
      applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
      checkOutput("pre_rst_occupancy", 32'(occupancy), 32'd3);
      checkOutput("pre_rst_starve", 32'(starve), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_head", 32'(head_flit), 32'h0);
      checkOutput("async_rst_occupancy", 32'(occupancy), 32'h0);
      checkOutput("async_rst_full", 32'(full), 32'h0);
      checkOutput("async_rst_starve", 32'(starve), 32'h0);
      checkOutput("async_rst_rand_num", 32'(rand_num), 32'h1);
      checkOutput("async_rst_redirect_cnt", 32'(redirect_cnt), 32'h0);

      $display("[TB] randomized traffic against reference model");
      doReset();
      for (int i = 0; i < 600; i++) begin
         pr  = ($urandom_range(0, 99) < 60);
         rg  = ($urandom_range(0, 99) < 40);
         if (mq.size() < DEPTH) rdg = ($urandom_range(0, 99) < 25);
         else                   rdg = ($urandom_range(0, 99) < 5);
         pf  = flit_int_t'($urandom);
         rf  = flit_int_t'($urandom);
         applyStimulus(pr, pf, rdg, rf, rg);
         @(negedge clk);
         modelAdvance(1'b1, $sformatf("rnd%0d", i));
         @(posedge clk);
         #1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
